// File: rtl/countdown_sequencer.sv
// Run-control FSM and BCD digit registers for the MM:SS countdown timer.
// Optional DONE_BLINK_EN macro: blink all digits while in DONE.
module countdown_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_pulse,
  input  logic       start_pulse,
  input  logic [7:0] load_value,
  output logic [3:0] minutes,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic [2:0] digit_blank
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("countdown_sequencer: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("countdown_sequencer: BLINK_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;

  logic       tick;
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic       dec_zero, count_zero;
  logic [3:0] ld_min, ld_tens;

  assign tick       = (state_q == RUN) && (presc_q == TICK_LAST);
  assign count_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign ld_min     = (load_value[7:4] > 4'd9) ? 4'd9 : load_value[7:4];
  assign ld_tens    = (load_value[3:0] > 4'd5) ? 4'd5 : load_value[3:0];

  // BCD borrow chain; only evaluated in RUN, where the count is never 0:00.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      if (tens_q == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end else begin
        dec_tens = tens_q - 4'd1;
      end
    end
    dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    if (set_pulse) begin
      state_d = IDLE;
      min_d   = ld_min;
      tens_d  = ld_tens;
      ones_d  = 4'd0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (start_pulse && !count_zero) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            min_d   = dec_min;
            tens_d  = dec_tens;
            ones_d  = dec_ones;
            presc_d = '0;
            if (dec_zero)         state_d = DONE;
            else if (start_pulse) state_d = PAUSE;
          end else if (start_pulse) begin
            // The pausing cycle does not count, so a resume continues
            // from exactly the phase the prescaler showed when paused.
            state_d = PAUSE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start_pulse) state_d = RUN;
        end
        DONE: begin
          presc_d = '0;
          if (start_pulse) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
    end
  end

  assign minutes  = min_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);

`ifdef DONE_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    blank_q, blank_d;

  always_comb begin
    bcnt_d  = bcnt_q + BW'(1);
    blank_d = blank_q;
    if (state_d != DONE || state_q != DONE) begin
      bcnt_d  = '0;
      blank_d = 3'b000;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      blank_d = ~blank_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcnt_q  <= '0;
      blank_q <= 3'b000;
    end else begin
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 3'b000;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer: vector table plus multi-cycle sequences.
module tb_countdown_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       set_pulse, start_pulse;
  logic [7:0] load_value;
  logic [3:0] minutes, sec_tens, sec_ones;
  logic       running, done;
  logic [2:0] digit_blank;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .BLINK_DIV(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .set_pulse   (set_pulse),
    .start_pulse (start_pulse),
    .load_value  (load_value),
    .minutes     (minutes),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .done        (done),
    .digit_blank (digit_blank)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       set;
    logic       start;
    logic [7:0] load;
    logic [3:0] e_min, e_tens, e_ones;
    logic       e_run, e_done;
  } vec_t;

  task automatic check(input string name, input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o, input logic r, input logic d, input logic [2:0] b);
    logic [14:0] act, exp;
    act = {minutes, sec_tens, sec_ones, running, done, digit_blank};
    exp = {m, t, o, r, d, b};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h:%0h%0h run=%0b done=%0b blank=%b, want %0h:%0h%0h run=%0b done=%0b blank=%b",
               name, minutes, sec_tens, sec_ones, running, done, digit_blank, m, t, o, r, d, b);
    end
  endtask

  // Inputs change 1 time unit after the edge; the pulse is seen by the next edge.
  task automatic pulse(input logic s, input logic st, input logic [7:0] lv);
    set_pulse   = s;
    start_pulse = st;
    load_value  = lv;
    @(posedge clock); #1;
    set_pulse   = 1'b0;
    start_pulse = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h12, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'hF9, 4'd9, 4'd5, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h5A, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h03, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h99, 4'd9, 4'd5, 4'd0, 1'b0, 1'b0};

    set_pulse   = 1'b0;
    start_pulse = 1'b0;
    load_value  = 8'h00;
    reset       = 1'b1;
    #1;
    check("reset_no_edge", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000);
    #13 reset = 1'b0;
    step(1);

    for (int i = 0; i < 11; i++) begin
      pulse(vecs[i].set, vecs[i].start, vecs[i].load);
      check($sformatf("vec%0d", i), vecs[i].e_min, vecs[i].e_tens, vecs[i].e_ones,
            vecs[i].e_run, vecs[i].e_done, 3'b000);
    end

    // 1:20 counting down: first decrement on the 10th RUN edge.
    pulse(1'b1, 1'b0, 8'h12);
    pulse(1'b0, 1'b1, 8'h00);
    step(9);
    check("run_before_tick", 4'd1, 4'd2, 4'd0, 1'b1, 1'b0, 3'b000);
    step(1);
    check("first_tick_1:19", 4'd1, 4'd1, 4'd9, 1'b1, 1'b0, 3'b000);
    step(70);
    check("80cyc_1:12", 4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 3'b000);

    // 0:10 runs to completion.
    pulse(1'b1, 1'b0, 8'h01);
    pulse(1'b0, 1'b1, 8'h00);
    step(99);
    check("last_second", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 3'b000);
    step(1);
    check("done_entry", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b000);
`ifdef DONE_BLINK_EN
    step(3);
    check("blink_dark_before", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b000);
    step(1);
    check("blink_on", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b111);
    step(3);
    check("blink_on_hold", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b111);
    step(1);
    check("blink_off_again", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b000);
    step(5);
    check("blink_on_second", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b111);
`else
    step(5);
    check("no_blink_a", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b000);
    step(8);
    check("no_blink_b", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b000);
`endif
    step(30);
    check("done_holds_0:00", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, digit_blank_exp_after(43));
    pulse(1'b0, 1'b1, 8'h00);
    check("done_to_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000);

    // Pause at prescaler 6, resume, decrement 4 edges later.
    pulse(1'b1, 1'b0, 8'h02);
    pulse(1'b0, 1'b1, 8'h00);
    step(50);
    check("run_to_0:15", 4'd0, 4'd1, 4'd5, 1'b1, 1'b0, 3'b000);
    step(6);
    pulse(1'b0, 1'b1, 8'h00);
    check("paused", 4'd0, 4'd1, 4'd5, 1'b0, 1'b0, 3'b000);
    step(40);
    check("pause_frozen", 4'd0, 4'd1, 4'd5, 1'b0, 1'b0, 3'b000);
    pulse(1'b0, 1'b1, 8'h00);
    step(3);
    check("resume_no_tick_yet", 4'd0, 4'd1, 4'd5, 1'b1, 1'b0, 3'b000);
    step(1);
    check("resume_tick_0:14", 4'd0, 4'd1, 4'd4, 1'b1, 1'b0, 3'b000);

    // set and start together in RUN: set wins, value clamped.
    pulse(1'b1, 1'b1, 8'hF9);
    check("set_beats_start", 4'd9, 4'd5, 4'd0, 1'b0, 1'b0, 3'b000);

    // Tick and start in the same cycle: decrement, then pause.
    pulse(1'b1, 1'b0, 8'h01);
    pulse(1'b0, 1'b1, 8'h00);
    step(9);
    pulse(1'b0, 1'b1, 8'h00);
    check("tick_and_pause", 4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 3'b000);
    step(20);
    check("tick_pause_frozen", 4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 3'b000);

    // Asynchronous reset between edges while running.
    pulse(1'b0, 1'b1, 8'h00);
    step(3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_mid_run", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000);
    #10 reset = 1'b0;
    step(2);
    check("idle_after_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Blank pattern expected after n DONE edges past entry (entry counts as 0).
  function automatic logic [2:0] digit_blank_exp_after(input int n);
`ifdef DONE_BLINK_EN
    return ((n / 4) % 2 == 1) ? 3'b111 : 3'b000;
`else
    return (n >= 0) ? 3'b000 : 3'b000;
`endif
  endfunction

endmodule
